// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_pkg
//   Shared types and default widths for the register-file writeback arbiter.
//   - wb_src_e : which source won the write port in a given cycle
//   - wb_req_t : one register-file write {addr, data} at the default widths
//   - WB_*     : default parameter values used by regfile_wb_arbiter
package regfile_wb_pkg;

  localparam int WB_D_WIDTH  = 32;
  localparam int WB_A_WIDTH  = 5;
  localparam int WB_LD_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LD,
    WB_SRC_ALU
  } wb_src_e;

  typedef struct packed {
    logic [WB_A_WIDTH-1:0] addr;
    logic [WB_D_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_sync_fifo
//   Small synchronous FIFO holding returning load responses until the
//   writeback port can take them. The head entry is visible combinationally
//   so the arbiter can select it in the same cycle it becomes valid.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data enqueue one entry (dropped if full)
//   pop             dequeue the head entry (ignored if empty)
//   head_data       current head entry
//   count           number of stored entries
//   full, empty     occupancy flags
module wb_sync_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 37,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             push_ok, pop_ok;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];

  // A push into a full queue is dropped so the stored entries stay intact.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Drives the register file's single write port from two sources: in-order
//   load responses (queued in a small FIFO, highest priority) and
//   single-cycle ALU results. Also tracks which registers have a load in
//   flight so decode can stall RAW/WAW hazards.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data ALU result handshake
//   ld_issue_valid/ready/rd            load issue handshake (scoreboard set)
//   ld_resp_valid/rd/data              returning load data, no backpressure
//   wb_we/wb_addr/wb_data              registered register-file write port
//   busy                               per-register pending-load mask
//   ld_outstanding                     issued loads not yet written back
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int D_WIDTH  = WB_D_WIDTH,
  parameter int A_WIDTH  = WB_A_WIDTH,
  parameter int LD_DEPTH = WB_LD_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [A_WIDTH-1:0]             alu_rd,
  input  logic [D_WIDTH-1:0]             alu_data,
  input  logic                           ld_issue_valid,
  output logic                           ld_issue_ready,
  input  logic [A_WIDTH-1:0]             ld_issue_rd,
  input  logic                           ld_resp_valid,
  input  logic [A_WIDTH-1:0]             ld_resp_rd,
  input  logic [D_WIDTH-1:0]             ld_resp_data,
  output logic                           wb_we,
  output logic [A_WIDTH-1:0]             wb_addr,
  output logic [D_WIDTH-1:0]             wb_data,
  output logic [2**A_WIDTH-1:0]          busy,
  output logic [$clog2(LD_DEPTH+1)-1:0]  ld_outstanding
);

  localparam int NREG  = 2**A_WIDTH;
  localparam int CNT_W = $clog2(LD_DEPTH + 1);

  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
  } req_t;

  logic [NREG-1:0]    busy_reg, busy_next;
  logic [CNT_W-1:0]   ld_cnt_reg, ld_cnt_next;
  logic               wb_we_reg, wb_we_next;
  logic [A_WIDTH-1:0] wb_addr_reg;
  logic [D_WIDTH-1:0] wb_data_reg;

  wb_src_e            sel_src;
  req_t               sel_req, resp_req, fifo_head;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               issue_fire, retire;

  assign resp_req.addr = ld_resp_rd;
  assign resp_req.data = ld_resp_data;

  wb_sync_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (A_WIDTH + D_WIDTH)
  ) u_ld_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ld_resp_valid),
    .push_data (resp_req),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The ALU also yields to a response arriving this cycle: that response
  // will be at the FIFO head next cycle, and loads must never be overtaken.
  assign alu_ready      = fifo_empty && !ld_resp_valid && !busy_reg[alu_rd];
  assign ld_issue_ready = (ld_cnt_reg < CNT_W'(LD_DEPTH)) && !busy_reg[ld_issue_rd];
  assign issue_fire     = ld_issue_valid && ld_issue_ready;

  // Fixed priority: FIFO head, then ALU.
  always_comb begin
    sel_src  = WB_SRC_NONE;
    sel_req  = '0;
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      sel_src  = WB_SRC_LD;
      sel_req  = fifo_head;
      fifo_pop = 1'b1;
    end else if (alu_valid && alu_ready) begin
      sel_src      = WB_SRC_ALU;
      sel_req.addr = alu_rd;
      sel_req.data = alu_data;
    end
  end

  // A selected load retires at the same edge its write lands, including x0.
  assign retire     = (sel_src == WB_SRC_LD);
  assign wb_we_next = (sel_src != WB_SRC_NONE) && (sel_req.addr != '0);

  always_comb begin
    ld_cnt_next = ld_cnt_reg;
    case ({issue_fire, retire})
      2'b10:   ld_cnt_next = ld_cnt_reg + CNT_W'(1);
      2'b01:   ld_cnt_next = ld_cnt_reg - CNT_W'(1);
      default: ld_cnt_next = ld_cnt_reg;
    endcase
  end

  // x0 is hardwired, so it never gets a pending bit. Set and clear cannot
  // collide on one register: issue is refused while that register is busy.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    logic set_hit, clr_hit;
    assign set_hit       = issue_fire && (ld_issue_rd == A_WIDTH'(gi));
    assign clr_hit       = retire && (fifo_head.addr == A_WIDTH'(gi));
    assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= '0;
      ld_cnt_reg  <= '0;
      wb_we_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
    end else begin
      busy_reg   <= busy_next;
      ld_cnt_reg <= ld_cnt_next;
      wb_we_reg  <= wb_we_next;
      // Address/data hold when idle to avoid needless toggling on the port.
      if (sel_src != WB_SRC_NONE) begin
        wb_addr_reg <= sel_req.addr;
        wb_data_reg <= sel_req.data;
      end
    end
  end

  assign wb_we          = wb_we_reg;
  assign wb_addr        = wb_addr_reg;
  assign wb_data        = wb_data_reg;
  assign busy           = busy_reg;
  assign ld_outstanding = ld_cnt_reg;

  // Every queued response belongs to an issued, unretired load.
  a_fifo_within_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= ld_cnt_reg);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Scoreboard bench: each stimulus that should produce a register write
//   pushes {addr, data} to a queue; a negedge monitor pops and compares
//   every wb_we pulse. Directed checks cover handshakes, busy and counts.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy;
  logic [1:0]  ld_outstanding;

  int n_checks = 0;
  int n_pass   = 0;
  wb_req_t sb[$];
  wb_req_t exp_req;
  int waited;

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_issue_rd    (ld_issue_rd),
    .ld_resp_valid  (ld_resp_valid),
    .ld_resp_rd     (ld_resp_rd),
    .ld_resp_data   (ld_resp_data),
    .wb_we          (wb_we),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .busy           (busy),
    .ld_outstanding (ld_outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_push(input logic [4:0] rd, input logic [31:0] data);
    wb_req_t e;
    e.addr = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  // Every write on the port must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wb_we) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", wb_we, 1'b0);
      end else begin
        exp_req = sb.pop_front();
        $display("wb write addr=%0d data=%08h (expected addr=%0d data=%08h)",
                 wb_addr, wb_data, exp_req.addr, exp_req.data);
        check("wb_addr", wb_addr, exp_req.addr);
        check("wb_data", wb_data, exp_req.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld_issue(input logic [4:0] rd, input logic exp_ready);
    ld_issue_rd    = rd;
    ld_issue_valid = 1'b1;
    #1;
    check("issue_ready", ld_issue_ready, exp_ready);
    @(posedge clk); #1;
    ld_issue_valid = 1'b0;
  endtask

  task automatic ld_resp(input logic [4:0] rd, input logic [31:0] data, input logic exp_write);
    ld_resp_rd    = rd;
    ld_resp_data  = data;
    ld_resp_valid = 1'b1;
    if (exp_write && rd != 5'd0) sb_push(rd, data);
    $display("load resp rd=%0d data=%08h", rd, data);
    @(posedge clk); #1;
    ld_resp_valid = 1'b0;
  endtask

  // Holds alu_valid until the handshake; samples ready at +2 so it never
  // races drivers that change inputs at +1 after the edge.
  task automatic alu_send(input logic [4:0] rd, input logic [31:0] data, output int n_wait);
    bit done;
    done      = 1'b0;
    n_wait    = 0;
    alu_rd    = rd;
    alu_data  = data;
    alu_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (alu_ready) begin
        if (rd != 5'd0) sb_push(rd, data);
        $display("alu accept rd=%0d data=%08h after %0d stall cycles", rd, data, n_wait);
        @(posedge clk); #1;
        done = 1'b1;
      end else begin
        n_wait++;
        @(posedge clk); #2;
      end
    end
    if (!done) check("alu_handshake_timeout", alu_ready, 1'b1);
    alu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue_valid = 1'b0; ld_issue_rd = '0;
    ld_resp_valid = 1'b0; ld_resp_rd = '0; ld_resp_data = '0;
    idle(3);

    // Reset state
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_addr", wb_addr, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_outstanding", ld_outstanding, 2'd0);
    check("rst_issue_ready", ld_issue_ready, 1'b1);
    check("rst_alu_ready", alu_ready, 1'b1);
    rst_n = 1'b1;
    idle(1);

    // ALU only
    alu_send(5'd5, 32'hDEADBEEF, waited);
    check("alu_wait", waited, 0);
    check("alu_wb_we", wb_we, 1'b1);
    check("alu_wb_addr", wb_addr, 5'd5);
    check("alu_wb_data", wb_data, 32'hDEADBEEF);
    check("alu_busy", busy, 32'd0);
    idle(2);

    // Load lifecycle
    ld_issue(5'd10, 1'b1);
    check("ld_busy_set", busy, 32'(1) << 10);
    check("ld_cnt_one", ld_outstanding, 2'd1);
    idle(2);
    ld_resp(5'd10, 32'h1234, 1'b1);
    check("ld_cnt_pending", ld_outstanding, 2'd1);
    check("ld_alu_blocked", alu_ready, 1'b0);
    idle(1);
    check("ld_wb_we", wb_we, 1'b1);
    check("ld_wb_addr", wb_addr, 5'd10);
    check("ld_busy_clear", busy, 32'd0);
    check("ld_cnt_zero", ld_outstanding, 2'd0);
    idle(1);

    // Outstanding limit and busy refusal
    ld_issue(5'd3, 1'b1);
    ld_issue(5'd4, 1'b1);
    check("lim_cnt_two", ld_outstanding, 2'd2);
    ld_issue_rd = 5'd7; #1;
    check("lim_ready_rd7", ld_issue_ready, 1'b0);
    ld_issue_rd = 5'd3; #1;
    check("lim_ready_rd3", ld_issue_ready, 1'b0);
    ld_resp(5'd3, 32'h33, 1'b1);
    idle(1);
    check("lim_cnt_after_retire", ld_outstanding, 2'd1);
    check("lim_busy_rd4", busy, 32'(1) << 4);
    ld_issue_rd = 5'd7; #1;
    check("lim_ready_rd7_free", ld_issue_ready, 1'b1);
    ld_issue_rd = 5'd4; #1;
    check("lim_ready_rd4_busy", ld_issue_ready, 1'b0);

    // Issue and retire in the same cycle: net count unchanged
    ld_resp(5'd4, 32'h44, 1'b1);
    ld_issue_rd = 5'd4; #1;
    check("retiring_rd_still_blocks", ld_issue_ready, 1'b0);
    ld_issue(5'd7, 1'b1);
    check("net0_cnt", ld_outstanding, 2'd1);
    check("net0_busy", busy, 32'(1) << 7);
    ld_resp(5'd7, 32'h77, 1'b1);
    idle(2);
    check("lim_drained_cnt", ld_outstanding, 2'd0);

    // Contention: response and ALU in the same cycle
    ld_issue(5'd8, 1'b1);
    idle(1);
    fork
      ld_resp(5'd8, 32'h88, 1'b1);
      alu_send(5'd9, 32'h99, waited);
      begin #1; check("contend_alu_ready", alu_ready, 1'b0); end
    join
    check("contend_alu_wait", waited, 2);
    idle(2);

    // ALU to a busy destination stalls until that load retires
    ld_issue(5'd3, 1'b1);
    fork
      alu_send(5'd3, 32'hCAFE0003, waited);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("stall_alu_ready", alu_ready, 1'b0);
        ld_resp(5'd3, 32'hBEEF0003, 1'b1);
      end
    join
    check("stall_alu_wait", waited, 5);
    check("stall_busy_clear", busy, 32'd0);
    idle(2);

    // x0 writes are consumed but never reach the register file
    alu_send(5'd0, 32'hFFFFFFFF, waited);
    check("x0_alu_wait", waited, 0);
    check("x0_alu_wb_we", wb_we, 1'b0);
    ld_issue(5'd0, 1'b1);
    check("x0_ld_cnt", ld_outstanding, 2'd1);
    check("x0_ld_busy", busy, 32'd0);
    ld_resp(5'd0, 32'hABCD, 1'b0);
    idle(1);
    check("x0_ld_cnt_zero", ld_outstanding, 2'd0);
    check("x0_ld_wb_we", wb_we, 1'b0);
    idle(1);

    // Reset mid-flight discards queued responses
    ld_issue(5'd11, 1'b1);
    ld_issue(5'd12, 1'b1);
    ld_resp(5'd11, 32'h1111, 1'b0);
    ld_resp(5'd12, 32'h1212, 1'b0);
    check("mid_wb_we_before", wb_we, 1'b1);
    check("mid_busy_before", busy, 32'(1) << 12);
    check("mid_cnt_before", ld_outstanding, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wb_we_async", wb_we, 1'b0);
    check("mid_busy_async", busy, 32'd0);
    check("mid_cnt_async", ld_outstanding, 2'd0);
    check("mid_fifo_flushed", alu_ready, 1'b1);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("post_rst_wb_we", wb_we, 1'b0);
    check("post_rst_wb_addr", wb_addr, 5'd0);
    check("post_rst_busy", busy, 32'd0);
    alu_send(5'd1, 32'hA5A5A5A5, waited);
    check("post_rst_alu_addr", wb_addr, 5'd1);
    idle(3);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
